// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types and helpers for the reset sequencer
//
// Purpose: FSM state encoding and the saturating sequence-count increment.
// Ports:   none (package).

package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        PULSE = 2'd1,
        RUN   = 2'd2
    } rst_seq_state_t;

    // 8-bit increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-channel staggered post-reset pulse generator
//
// Purpose: after the external reset falls, holds every channel of rst_out high
//          for PULSE_CYCLES cycles, then releases channel k a further
//          k*STAGGER cycles later. In RUN a soft_req restarts the same sequence.
// Ports:
//   clk       in   core clock
//   reset     in   asynchronous active-high reset
//   soft_req  in   level request for a new sequence (sampled only in RUN)
//   soft_ack  out  one-cycle pulse when soft_req is accepted
//   rst_out   out  [NUM_CH] per-channel active-high downstream resets
//   busy      out  sequence in progress or pending
//   done      out  all channels released
//   seq_count out  [8] completed sequences, saturating at 255

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PULSE_CYCLES  = 1,
    parameter int STAGGER       = 1,
    parameter int HOLD_IN_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_req,
    output logic              soft_ack,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        seq_count
);

    // Counter value at which the last channel releases; the counter never
    // needs to exceed it, so the width is sized to hold exactly that.
    localparam int LAST  = PULSE_CYCLES + (NUM_CH - 1) * STAGGER;
    localparam int CNT_W = $clog2(LAST + 1);

    localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(LAST);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_CH-1:0] RST_IDLE = (HOLD_IN_RESET != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    generate
        if (NUM_CH < 1 || PULSE_CYCLES < 1 || STAGGER < 0) begin : g_bad_params
            $error("reset_sequencer: illegal parameters (NUM_CH>=1, PULSE_CYCLES>=1, STAGGER>=0)");
        end
    endgenerate

    rst_seq_state_t    state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] rst_d;
    logic              ack_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        seq_q;

    // A channel drops when the counter reaches its own threshold and then
    // stays low; the hold term keeps it low for the rest of the sequence.
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_rel
            localparam logic [CNT_W-1:0] THR_C = CNT_W'(PULSE_CYCLES + k * STAGGER);
            assign rst_d[k] = rst_q[k] & (cnt_q != THR_C);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rst_q   <= RST_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            seq_q   <= 8'd0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                INIT: begin
                    state_q <= PULSE;
                    rst_q   <= '1;
                    cnt_q   <= CNT_ONE;
                end
                PULSE: begin
                    rst_q <= rst_d;
                    if (cnt_q == LAST_C) begin
                        // Last channel falls on this edge; counter parks here.
                        state_q <= RUN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        seq_q   <= sat_inc8(seq_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (soft_req) begin
                        ack_q   <= 1'b1;
                        state_q <= PULSE;
                        rst_q   <= '1;
                        cnt_q   <= CNT_ONE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign soft_ack  = ack_q;
    assign rst_out   = rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign seq_count = seq_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer

module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       ack;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       reset_a, soft_a, ack_a, busy_a, done_a;
    logic [2:0] rst_a;
    logic [7:0] cnt_a;
    logic       reset_b, soft_b, ack_b, busy_b, done_b;
    logic [0:0] rst_b;
    logic [7:0] cnt_b;
    logic       reset_c, soft_c, ack_c, busy_c, done_c;
    logic [1:0] rst_c;
    logic [7:0] cnt_c;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Hand-computed rst_out for A (3 ch, pulse 4, stagger 2) at E0+0..E0+8.
    localparam logic [2:0] A_RST [9] = '{3'b111, 3'b111, 3'b111, 3'b111,
                                         3'b110, 3'b110, 3'b100, 3'b100, 3'b000};

    reset_sequencer #(.NUM_CH(3), .PULSE_CYCLES(4), .STAGGER(2), .HOLD_IN_RESET(1)) dut_a (
        .clk(clk), .reset(reset_a), .soft_req(soft_a), .soft_ack(ack_a),
        .rst_out(rst_a), .busy(busy_a), .done(done_a), .seq_count(cnt_a));

    reset_sequencer #(.NUM_CH(1), .PULSE_CYCLES(1), .STAGGER(1), .HOLD_IN_RESET(0)) dut_b (
        .clk(clk), .reset(reset_b), .soft_req(soft_b), .soft_ack(ack_b),
        .rst_out(rst_b), .busy(busy_b), .done(done_b), .seq_count(cnt_b));

    reset_sequencer #(.NUM_CH(2), .PULSE_CYCLES(2), .STAGGER(0), .HOLD_IN_RESET(0)) dut_c (
        .clk(clk), .reset(reset_c), .soft_req(soft_c), .soft_ack(ack_c),
        .rst_out(rst_c), .busy(busy_c), .done(done_c), .seq_count(cnt_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int off, input logic [2:0] r, input logic a,
                        input logic b, input logic dn, input logic [7:0] c);
        exp_t e;
        e.cyc = cyc + off; e.rst = r; e.ack = a; e.busy = b; e.done = dn; e.cnt = c;
        if (d == 0) qa.push_back(e);
        else if (d == 1) qb.push_back(e);
        else qc.push_back(e);
    endtask

    task automatic compare(input string nm, input exp_t e, input logic [2:0] r, input logic a,
                           input logic b, input logic dn, input logic [7:0] c);
        total++;
        if (e.cyc != cyc || {r, a, b, dn, c} !== {e.rst, e.ack, e.busy, e.done, e.cnt}) begin
            bad++;
            $display("FAIL %s cyc=%0d(want %0d) got rst_out=%b ack=%b busy=%b done=%b seq=%0d want rst_out=%b ack=%b busy=%b done=%b seq=%0d",
                     nm, cyc, e.cyc, r, a, b, dn, c, e.rst, e.ack, e.busy, e.done, e.cnt);
        end
    endtask

    // Monitor: pops every expectation due this cycle and checks the sampled outputs.
    always @(negedge clk) begin
        exp_t e;
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            compare("dut_a", e, rst_a, ack_a, busy_a, done_a, cnt_a);
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            compare("dut_b", e, {2'b00, rst_b}, ack_b, busy_b, done_b, cnt_b);
        end
        while (qc.size() > 0 && qc[0].cyc <= cyc) begin
            e = qc.pop_front();
            compare("dut_c", e, {1'b0, rst_c}, ack_c, busy_c, done_c, cnt_c);
        end
    end

    // One full A sequence started by reset release or soft_req; poke_at pulses
    // soft_req during PULSE at that edge offset, which must be ignored.
    task automatic a_seq(input bit via_soft, input logic [7:0] prev, input logic [7:0] after,
                         input int poke_at);
        if (via_soft) soft_a = 1'b1;
        else reset_a = 1'b0;
        for (int j = 0; j < 9; j++)
            push(0, j + 1, A_RST[j], via_soft && j == 0, j < 8, j == 8, (j == 8) ? after : prev);
        step();
        soft_a = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            if (j == poke_at) soft_a = 1'b1;
            step();
            soft_a = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] nxt;
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        soft_a = 1'b0; soft_b = 1'b0; soft_c = 1'b0;
        step(); step(); step();

        // A: hold-in-reset values, staggered release, soft restart, mid-pulse reset.
        push(0, 0, 3'b111, 1'b0, 1'b1, 1'b0, 8'd0);
        a_seq(1'b0, 8'd0, 8'd1, 0);
        push(0, 1, 3'b000, 1'b0, 1'b0, 1'b1, 8'd1);
        step();
        a_seq(1'b1, 8'd1, 8'd2, 3);
        soft_a = 1'b1;
        push(0, 1, 3'b111, 1'b1, 1'b1, 1'b0, 8'd2);
        step();
        soft_a = 1'b0;
        step();
        reset_a = 1'b1;
        push(0, 0, 3'b111, 1'b0, 1'b1, 1'b0, 8'd0);
        step();
        push(0, 0, 3'b111, 1'b0, 1'b1, 1'b0, 8'd0);
        a_seq(1'b0, 8'd0, 8'd1, 0);

        // C: zero stagger releases both channels together.
        push(2, 0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0);
        reset_c = 1'b0;
        push(2, 1, 3'b011, 1'b0, 1'b1, 1'b0, 8'd0);
        push(2, 2, 3'b011, 1'b0, 1'b1, 1'b0, 8'd0);
        push(2, 3, 3'b000, 1'b0, 1'b0, 1'b1, 8'd1);
        push(2, 4, 3'b000, 1'b0, 1'b0, 1'b1, 8'd1);
        step(); step(); step(); step();

        // B: legacy one-cycle pulse, then soft_req held for 300 sequences.
        push(1, 0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0);
        reset_b = 1'b0;
        push(1, 1, 3'b001, 1'b0, 1'b1, 1'b0, 8'd0);
        push(1, 2, 3'b000, 1'b0, 1'b0, 1'b1, 8'd1);
        step(); step();
        soft_b = 1'b1;
        prev = 8'd1;
        for (int i = 0; i < 300; i++) begin
            nxt = (prev == 8'd255) ? 8'd255 : prev + 8'd1;
            push(1, 1, 3'b001, 1'b1, 1'b1, 1'b0, prev);
            push(1, 2, 3'b000, 1'b0, 1'b0, 1'b1, nxt);
            step(); step();
            prev = nxt;
        end
        soft_b = 1'b0;
        push(1, 1, 3'b000, 1'b0, 1'b0, 1'b1, 8'd255);
        step();

        for (int w = 0; w < 20 && (qa.size() + qb.size() + qc.size()) > 0; w++) step();
        if ((qa.size() + qb.size() + qc.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want 0", qa.size() + qb.size() + qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
